// File: rtl/cm_xfer_seq.sv
// CM bus master transfer sequencer: waits for a start token, then sends payload
// words one at a time, each needing an ACK, with NACK/timeout resends.
module cm_xfer_seq #(
  parameter int unsigned    DW          = 8,
  parameter logic [DW-1:0]  START_TOK   = DW'(8'hCC),
  parameter logic [DW-1:0]  ACK_TOK     = DW'(8'hA5),
  parameter logic [DW-1:0]  ALT_ACK_TOK = DW'(8'h5A),
  parameter logic [DW-1:0]  NACK_TOK    = DW'(8'hEE),
  parameter int unsigned    TIMEOUT     = 1000,
  parameter int unsigned    TO_W        = 16,
  parameter int unsigned    MAX_RETRY   = 3,
  parameter logic [DW-1:0]  LFSR_TAPS   = DW'(8'hB8)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          drive_en,
  output logic [2:0]    state_o,
  output logic [15:0]   xfer_cnt,
  output logic [7:0]    err_cnt,
  output logic          fail
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned RTY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_FAIL = 3'd3
  } state_t;

  state_t             state, state_nxt;
  logic [TO_W-1:0]    timer, timer_nxt;
  logic [RTY_W-1:0]   retry, retry_nxt;
  logic               mode_q, mode_nxt;
  logic [DW-1:0]      data_nxt;
  logic [CNT_W-1:0]   xfer_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic               fail_nxt;
  logic               listen, is_ack, is_nack, timed_out;

  // Increment or Galois right-shift LFSR step
  function automatic logic [DW-1:0] next_word(input logic [DW-1:0] w, input logic lfsr);
    if (lfsr) return (w >> 1) ^ (w[0] ? LFSR_TAPS : '0);
    return w + DW'(1);
  endfunction

  // First WAIT cycle is bus turnaround: our own echo must not be decoded
  assign listen    = (timer != '0);
  assign is_ack    = listen && ((data_in == ACK_TOK) || (data_in == ALT_ACK_TOK));
  assign is_nack   = listen && (data_in == NACK_TOK);
  assign timed_out = (timer == TO_W'(TIMEOUT - 1));
  assign state_o   = state;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry;
    mode_nxt  = mode_q;
    data_nxt  = data_out;
    xfer_nxt  = xfer_cnt;
    err_nxt   = err_cnt;
    fail_nxt  = fail;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_in == START_TOK) begin
            state_nxt = ST_SEND;
            mode_nxt  = mode;
            // A fresh session starts with its full resend allowance
            retry_nxt = '0;
            if (mode && (data_out == '0)) data_nxt = DW'(1);
          end
        end
        ST_SEND: begin
          state_nxt = ST_WAIT;
          timer_nxt = '0;
        end
        ST_WAIT: begin
          timer_nxt = timer + TO_W'(1);
          if (is_ack) begin
            data_nxt  = next_word(data_out, mode_q);
            xfer_nxt  = xfer_cnt + CNT_W'(1);
            retry_nxt = '0;
            state_nxt = ST_SEND;
          end else if (is_nack || timed_out) begin
            if (err_cnt != '1) err_nxt = err_cnt + ERR_W'(1);
            if (retry < RTY_W'(MAX_RETRY)) begin
              retry_nxt = retry + RTY_W'(1);
              state_nxt = ST_SEND;
            end else begin
              state_nxt = ST_FAIL;
              fail_nxt  = 1'b1;
            end
          end
        end
        ST_FAIL: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      retry    <= '0;
      mode_q   <= 1'b0;
      data_out <= '0;
      xfer_cnt <= '0;
      err_cnt  <= '0;
      fail     <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      retry    <= retry_nxt;
      mode_q   <= mode_nxt;
      data_out <= data_nxt;
      xfer_cnt <= xfer_nxt;
      err_cnt  <= err_nxt;
      fail     <= fail_nxt;
      drive_en <= (state_nxt == ST_SEND);
    end
  end

endmodule

// File: tb/tb_cm_xfer_seq.sv
// Bench for cm_xfer_seq: directed bus scenarios then random traffic, every
// cycle compared against a token-level reference model.
module tb_cm_xfer_seq;

  localparam int unsigned TO = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        drive_en;
  logic [2:0]  state_o;
  logic [15:0] xfer_cnt;
  logic [7:0]  err_cnt;
  logic        fail;

  int n_checks = 0;
  int n_fail   = 0;

  cm_xfer_seq #(.DW(8), .TIMEOUT(TO), .TO_W(16), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .data_out(data_out), .drive_en(drive_en), .state_o(state_o),
    .xfer_cnt(xfer_cnt), .err_cnt(err_cnt), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 sending, 2 awaiting reply, 3 failed
  int          m_phase, m_wait, m_resends, m_err;
  logic [7:0]  m_word;
  logic [15:0] m_xfer;
  bit          m_lfsr, m_fail;

  function automatic logic [7:0] m_adv(input logic [7:0] w, input bit lfsr);
    if (lfsr) return (w >> 1) ^ (((w % 2) == 1) ? 8'hB8 : 8'h00);
    return 8'((int'(w) + 1) % 256);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_resends = 0; m_err = 0;
    m_word = 8'h00; m_xfer = 16'h0; m_lfsr = 0; m_fail = 0;
  endtask

  task automatic model_step(input bit e, input bit md, input logic [7:0] d);
    bit ack, nack, late;
    if (!e) begin
      m_phase = 0;
      return;
    end
    if (m_phase == 0) begin
      if (d == 8'hCC) begin
        m_lfsr = md; m_resends = 0; m_phase = 1;
        if (md && m_word == 8'h00) m_word = 8'h01;
      end
    end else if (m_phase == 1) begin
      m_wait = 0; m_phase = 2;
    end else if (m_phase == 2) begin
      ack  = (m_wait >= 1) && (d == 8'hA5 || d == 8'h5A);
      nack = (m_wait >= 1) && (d == 8'hEE);
      late = (m_wait == int'(TO) - 1);
      m_wait++;
      if (ack) begin
        m_word = m_adv(m_word, m_lfsr); m_xfer = m_xfer + 16'd1;
        m_resends = 0; m_phase = 1;
      end else if (nack || late) begin
        if (m_err < 255) m_err++;
        if (m_resends < 3) begin
          m_resends++; m_phase = 1;
        end else begin
          m_phase = 3; m_fail = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("state", 32'(state_o), 32'(m_phase));
    check("drive_en", 32'(drive_en), 32'(m_phase == 1));
    check("data_out", 32'(data_out), 32'(m_word));
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("fail", 32'(fail), 32'(m_fail));
  endtask

  task automatic step(input bit e, input bit md, input logic [7:0] d);
    en = e; mode = md; data_in = d;
    @(posedge clk);
    model_step(e, md, d);
    #1;
    compare_all();
  endtask

  // From SEND: echo, ack during turnaround (must be ignored), ack again
  task automatic ack_word(input logic [7:0] exp_w, input logic [7:0] ack);
    check("send_word", 32'(data_out), 32'(exp_w));
    check("send_drive", 32'(drive_en), 32'd1);
    step(1, 0, exp_w);
    step(1, 0, ack);
    step(1, 0, ack);
  endtask

  task automatic do_reset();
    rst = 1; en = 0; mode = 0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 0;
  endtask

  initial begin
    int r;
    bit e, md;
    logic [7:0] d;

    // Basic three-word session
    do_reset();
    step(1, 0, 8'hCC);
    for (int i = 0; i < 3; i++) ack_word(8'(i), 8'hA5);
    check("xfer_after3", 32'(xfer_cnt), 32'd3);
    check("err_after3", 32'(err_cnt), 32'd0);

    // Increment wrap FF -> 00
    for (int i = 3; i < 256; i++) ack_word(8'(i), (i % 2 == 0) ? 8'hA5 : 8'h5A);
    check("wrap_word", 32'(data_out), 32'h00);
    check("wrap_xfer", 32'(xfer_cnt), 32'd256);

    // LFSR session from a zero word
    step(0, 0, 8'h00);
    step(1, 1, 8'hCC);
    ack_word(8'h01, 8'h5A);
    ack_word(8'hB8, 8'h5A);
    check("lfsr_third", 32'(data_out), 32'h5C);

    // NACK exhaustion on word 07
    do_reset();
    step(1, 0, 8'hCC);
    for (int i = 0; i < 7; i++) ack_word(8'(i), 8'hA5);
    for (int k = 0; k < 4; k++) begin
      check("nack_word", 32'(data_out), 32'h07);
      check("nack_drive", 32'(drive_en), 32'd1);
      step(1, 0, 8'h07);
      step(1, 0, 8'hEE);
      step(1, 0, 8'hEE);
    end
    check("nack_state", 32'(state_o), 32'd3);
    check("nack_fail", 32'(fail), 32'd1);
    check("nack_err", 32'(err_cnt), 32'd4);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, (k % 2 == 0) ? 8'hCC : 8'hA5);
      check("fail_drive", 32'(drive_en), 32'd0);
    end

    // Timeout resend, then ACK landing on the timeout cycle
    step(0, 0, 8'h00);
    step(1, 0, 8'hCC);
    for (int k = 0; k < int'(TO) + 1; k++) step(1, 0, 8'h00);
    check("to_resend", 32'(drive_en), 32'd1);
    check("to_err", 32'(err_cnt), 32'd5);
    for (int k = 0; k < int'(TO); k++) step(1, 0, 8'h00);
    step(1, 0, 8'hA5);
    check("to_ack_word", 32'(data_out), 32'h08);
    check("to_ack_err", 32'(err_cnt), 32'd5);
    check("fail_sticky", 32'(fail), 32'd1);

    // Async reset mid-WAIT
    step(1, 0, 8'h08);
    step(1, 0, 8'h00);
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst = 0;

    // en drop mid-WAIT, then resume from retained word
    step(1, 0, 8'hCC);
    ack_word(8'h00, 8'hA5);
    ack_word(8'h01, 8'hA5);
    step(1, 0, 8'h02);
    step(0, 0, 8'h00);
    check("endrop_state", 32'(state_o), 32'd0);
    check("endrop_word", 32'(data_out), 32'h02);
    check("endrop_xfer", 32'(xfer_cnt), 32'd2);
    step(1, 0, 8'hCC);
    check("resume_word", 32'(data_out), 32'h02);
    check("resume_drive", 32'(drive_en), 32'd1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      e  = ($urandom % 25) != 0;
      md = ($urandom % 2) == 1;
      r  = int'($urandom % 10);
      case (r)
        0, 1:    d = 8'hA5;
        2:       d = 8'h5A;
        3:       d = 8'hEE;
        4:       d = 8'hCC;
        default: d = 8'($urandom);
      endcase
      step(e, md, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
